// File: rtl/delay_stream_scheduler.sv
// Two ready/valid input streams share one fixed-latency delay pipeline under round-robin arbitration.
// Each beat leaves on the crossed or straight output. Defining DELAY_SCHED_SVA_EN compiles the protocol assertions.
module delay_stream_scheduler #(
  parameter int WIDTH = 5,
  parameter int DEPTH = 3,
  parameter int SWAP  = 1
) (
  input  logic                       CLK,
  input  logic                       ASYNCRESET,
  input  logic [WIDTH-1:0]           INPUT_0_data,
  input  logic                       INPUT_0_valid,
  output logic                       INPUT_0_ready,
  input  logic [WIDTH-1:0]           INPUT_1_data,
  input  logic                       INPUT_1_valid,
  output logic                       INPUT_1_ready,
  output logic [WIDTH-1:0]           OUTPUT_0_data,
  output logic                       OUTPUT_0_valid,
  input  logic                       OUTPUT_0_ready,
  output logic [WIDTH-1:0]           OUTPUT_1_data,
  output logic                       OUTPUT_1_valid,
  input  logic                       OUTPUT_1_ready,
  output logic                       busy,
  output logic [$clog2(DEPTH+1)-1:0] occupancy
);

  localparam int OCC_W = $clog2(DEPTH+1);
  localparam int HEAD  = DEPTH - 1;

  logic [DEPTH-1:0] r_vld;
  logic [DEPTH-1:0] r_tag;
  logic [WIDTH-1:0] r_data [DEPTH];
  logic             r_prio;
  logic [OCC_W-1:0] r_occ;

  logic             w_head_vld;
  logic             w_head_dest;
  logic             w_dest_ready;
  logic             w_advance;
  logic             w_drain;
  logic             w_both_req;
  logic             w_gnt0;
  logic             w_gnt1;
  logic             w_xfer0;
  logic             w_xfer1;
  logic             w_accept;
  logic [WIDTH-1:0] w_in_data;

  // The whole pipeline moves together, so a stalled head blocks beats for both outputs.
  assign w_head_vld   = r_vld[HEAD];
  assign w_head_dest  = (SWAP != 0) ? ~r_tag[HEAD] : r_tag[HEAD];
  assign w_dest_ready = w_head_dest ? OUTPUT_1_ready : OUTPUT_0_ready;
  assign w_advance    = ~w_head_vld | w_dest_ready;
  assign w_drain      = w_head_vld & w_dest_ready;

  assign w_both_req = INPUT_0_valid & INPUT_1_valid;
  assign w_gnt0     = INPUT_0_valid & (~INPUT_1_valid | ~r_prio);
  assign w_gnt1     = INPUT_1_valid & (~INPUT_0_valid | r_prio);

  assign INPUT_0_ready = w_advance & w_gnt0;
  assign INPUT_1_ready = w_advance & w_gnt1;

  assign w_xfer0   = INPUT_0_valid & INPUT_0_ready;
  assign w_xfer1   = INPUT_1_valid & INPUT_1_ready;
  assign w_accept  = w_xfer0 | w_xfer1;
  assign w_in_data = w_xfer1 ? INPUT_1_data :
                     w_xfer0 ? INPUT_0_data : '0;

  always_ff @(posedge CLK or posedge ASYNCRESET) begin
    if (ASYNCRESET) begin
      r_vld <= '0;
      r_tag <= '0;
      for (int i = 0; i < DEPTH; i++) r_data[i] <= '0;
    end else if (w_advance) begin
      for (int i = DEPTH - 1; i > 0; i--) begin
        r_vld[i]  <= r_vld[i-1];
        r_tag[i]  <= r_tag[i-1];
        r_data[i] <= r_data[i-1];
      end
      r_vld[0]  <= w_accept;
      r_tag[0]  <= w_xfer1;
      r_data[0] <= w_in_data;
    end
  end

  // A both-requesting cycle with advance=1 always completes a transfer.
  always_ff @(posedge CLK or posedge ASYNCRESET) begin
    if (ASYNCRESET) begin
      r_prio <= 1'b0;
    end else if (w_both_req & w_advance) begin
      r_prio <= ~r_prio;
    end
  end

  always_ff @(posedge CLK or posedge ASYNCRESET) begin
    if (ASYNCRESET) begin
      r_occ <= '0;
    end else if (w_accept & ~w_drain) begin
      r_occ <= r_occ + OCC_W'(1);
    end else if (~w_accept & w_drain) begin
      r_occ <= r_occ - OCC_W'(1);
    end
  end

  assign OUTPUT_0_valid = w_head_vld & ~w_head_dest;
  assign OUTPUT_1_valid = w_head_vld &  w_head_dest;
  assign OUTPUT_0_data  = OUTPUT_0_valid ? r_data[HEAD] : '0;
  assign OUTPUT_1_data  = OUTPUT_1_valid ? r_data[HEAD] : '0;
  assign occupancy      = r_occ;
  assign busy           = (r_occ != '0);

`ifdef DELAY_SCHED_SVA_EN
  a_out0_hold: assert property (@(posedge CLK) disable iff (ASYNCRESET)
    OUTPUT_0_valid && !OUTPUT_0_ready |=> $stable(OUTPUT_0_valid) && $stable(OUTPUT_0_data));
  a_out1_hold: assert property (@(posedge CLK) disable iff (ASYNCRESET)
    OUTPUT_1_valid && !OUTPUT_1_ready |=> $stable(OUTPUT_1_valid) && $stable(OUTPUT_1_data));
  a_ready_excl: assert property (@(posedge CLK) disable iff (ASYNCRESET)
    !(INPUT_0_ready && INPUT_1_ready));
  a_occ_range: assert property (@(posedge CLK) disable iff (ASYNCRESET)
    int'(occupancy) <= DEPTH);
  a_lat0: assert property (@(posedge CLK) disable iff (ASYNCRESET)
    (w_xfer0 ##0 w_advance [*DEPTH]) |=> ((SWAP != 0) ? OUTPUT_1_valid : OUTPUT_0_valid));
  a_lat1: assert property (@(posedge CLK) disable iff (ASYNCRESET)
    (w_xfer1 ##0 w_advance [*DEPTH]) |=> ((SWAP != 0) ? OUTPUT_0_valid : OUTPUT_1_valid));
`endif

endmodule

// File: tb/tb_delay_stream_scheduler.sv
// Bench for delay_stream_scheduler: directed scenarios plus random traffic checked
// against a slot-queue reference model and an in-order payload scoreboard.
module tb_delay_stream_scheduler;

  localparam int WIDTH = 5;
  localparam int DEPTH = 3;
  localparam int SWAP  = 1;
  localparam int OCC_W = $clog2(DEPTH+1);

  typedef struct packed {
    logic             vld;
    logic             tag;
    logic [WIDTH-1:0] data;
  } beat_t;

  logic             CLK = 1'b0;
  logic             ASYNCRESET;
  logic [WIDTH-1:0] in0_data, in1_data, out0_data, out1_data;
  logic             in0_valid, in1_valid, in0_ready, in1_ready;
  logic             out0_valid, out1_valid, out0_ready, out1_ready;
  logic             busy;
  logic [OCC_W-1:0] occupancy;

  logic [WIDTH-1:0] ns_in0_data, ns_in1_data, ns_out0_data, ns_out1_data;
  logic             ns_in0_valid, ns_in1_valid, ns_in0_ready, ns_in1_ready;
  logic             ns_out0_valid, ns_out1_valid;
  logic             ns_busy;
  logic [OCC_W-1:0] ns_occupancy;

  always #5 CLK = ~CLK;

  delay_stream_scheduler #(.WIDTH(WIDTH), .DEPTH(DEPTH), .SWAP(SWAP)) u_dut (
    .CLK(CLK), .ASYNCRESET(ASYNCRESET),
    .INPUT_0_data(in0_data), .INPUT_0_valid(in0_valid), .INPUT_0_ready(in0_ready),
    .INPUT_1_data(in1_data), .INPUT_1_valid(in1_valid), .INPUT_1_ready(in1_ready),
    .OUTPUT_0_data(out0_data), .OUTPUT_0_valid(out0_valid), .OUTPUT_0_ready(out0_ready),
    .OUTPUT_1_data(out1_data), .OUTPUT_1_valid(out1_valid), .OUTPUT_1_ready(out1_ready),
    .busy(busy), .occupancy(occupancy)
  );

  delay_stream_scheduler #(.WIDTH(WIDTH), .DEPTH(DEPTH), .SWAP(0)) u_dut_straight (
    .CLK(CLK), .ASYNCRESET(ASYNCRESET),
    .INPUT_0_data(ns_in0_data), .INPUT_0_valid(ns_in0_valid), .INPUT_0_ready(ns_in0_ready),
    .INPUT_1_data(ns_in1_data), .INPUT_1_valid(ns_in1_valid), .INPUT_1_ready(ns_in1_ready),
    .OUTPUT_0_data(ns_out0_data), .OUTPUT_0_valid(ns_out0_valid), .OUTPUT_0_ready(1'b1),
    .OUTPUT_1_data(ns_out1_data), .OUTPUT_1_valid(ns_out1_valid), .OUTPUT_1_ready(1'b1),
    .busy(ns_busy), .occupancy(ns_occupancy)
  );

  // Reference model: m_pipe[0] is the head slot; m_sb holds accepted payloads not yet drained.
  beat_t            m_pipe[$];
  logic [WIDTH-1:0] m_sb[$];
  logic             m_prio;
  int               n_vec;
  int               n_err;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_pipe.delete();
    for (int i = 0; i < DEPTH; i++) m_pipe.push_back('0);
    m_sb.delete();
    m_prio = 1'b0;
  endtask

  task automatic idle_inputs();
    in0_valid = 1'b0; in1_valid = 1'b0;
    in0_data  = '0;   in1_data  = '0;
  endtask

  // Called just after a falling edge with inputs driven; checks, updates the model, waits one cycle.
  task automatic cycle();
    beat_t            head, nb;
    logic             dest, adv, req, g, exp_v0, exp_v1;
    logic [WIDTH-1:0] sb_head;
    int               cnt;
    #1;
    head   = m_pipe[0];
    dest   = (SWAP != 0) ? ~head.tag : head.tag;
    adv    = !head.vld || (dest ? out1_ready : out0_ready);
    req    = in0_valid || in1_valid;
    g      = (in0_valid && in1_valid) ? m_prio : in1_valid;
    exp_v0 = head.vld && !dest;
    exp_v1 = head.vld && dest;
    cnt    = 0;
    foreach (m_pipe[i]) if (m_pipe[i].vld) cnt++;
    chk("in0_ready",  32'(in0_ready),  32'(adv && req && !g));
    chk("in1_ready",  32'(in1_ready),  32'(adv && req && g));
    chk("out0_valid", 32'(out0_valid), 32'(exp_v0));
    chk("out1_valid", 32'(out1_valid), 32'(exp_v1));
    chk("out0_data",  32'(out0_data),  32'(exp_v0 ? head.data : 5'd0));
    chk("out1_data",  32'(out1_data),  32'(exp_v1 ? head.data : 5'd0));
    chk("busy",       32'(busy),       32'(cnt != 0));
    chk("occupancy",  32'(occupancy),  32'(cnt));
    if (head.vld && adv && m_sb.size() > 0) begin
      sb_head = m_sb.pop_front();
      chk("drain_order", 32'(dest ? out1_data : out0_data), 32'(sb_head));
    end
    if (adv) begin
      m_pipe.delete(0);
      nb = '0;
      if (req) begin
        nb.vld  = 1'b1;
        nb.tag  = g;
        nb.data = g ? in1_data : in0_data;
        m_sb.push_back(nb.data);
      end
      m_pipe.push_back(nb);
      if (in0_valid && in1_valid) m_prio = ~m_prio;
    end
    @(negedge CLK);
  endtask

  // Called just after a falling edge; asserts reset between edges and checks outputs at once.
  task automatic do_reset();
    #3 ASYNCRESET = 1'b1;
    #1;
    chk("rst_out0_valid", 32'(out0_valid), 32'd0);
    chk("rst_out1_valid", 32'(out1_valid), 32'd0);
    chk("rst_out0_data",  32'(out0_data),  32'd0);
    chk("rst_out1_data",  32'(out1_data),  32'd0);
    chk("rst_busy",       32'(busy),       32'd0);
    chk("rst_occupancy",  32'(occupancy),  32'd0);
    model_reset();
    @(negedge CLK);
    #2 ASYNCRESET = 1'b0;
    @(negedge CLK);
  endtask

  initial begin
    logic [WIDTH-1:0] d0, d1, ns_got;
    int               lat;
    logic             seen0;
    n_vec = 0;
    n_err = 0;
    ASYNCRESET = 1'b1;
    idle_inputs();
    out0_ready = 1'b1; out1_ready = 1'b1;
    ns_in0_valid = 1'b0; ns_in1_valid = 1'b0;
    ns_in0_data  = '0;   ns_in1_data  = '0;
    model_reset();

    @(negedge CLK);
    #1;
    chk("por_out0_valid", 32'(out0_valid), 32'd0);
    chk("por_out1_valid", 32'(out1_valid), 32'd0);
    chk("por_busy",       32'(busy),       32'd0);
    chk("por_occupancy",  32'(occupancy),  32'd0);
    #2 ASYNCRESET = 1'b0;
    @(negedge CLK);

    // Single beat from channel 0 reaches OUTPUT_1 three cycles later.
    in0_valid = 1'b1; in0_data = 5'h0A;
    cycle();
    idle_inputs();
    cycle();
    cycle();
    #1;
    chk("t1_out1_valid", 32'(out1_valid), 32'd1);
    chk("t1_out1_data",  32'(out1_data),  32'h0A);
    chk("t1_out0_valid", 32'(out0_valid), 32'd0);
    cycle();
    cycle();

    // Both channels requesting: grants alternate starting with channel 0.
    d0 = 5'h01; d1 = 5'h11;
    for (int k = 0; k < 8; k++) begin
      in0_valid = 1'b1; in1_valid = 1'b1;
      in0_data  = d0;   in1_data  = d1;
      #1 chk("t2_grant1", 32'(in1_ready), 32'(k % 2));
      cycle();
      if (k % 2 == 0) d0 = d0 + 5'd1;
      else            d1 = d1 + 5'd1;
    end
    idle_inputs();
    for (int k = 0; k < DEPTH + 1; k++) cycle();

    // Fill, then hold OUTPUT_1 off: the whole pipeline freezes.
    for (int k = 0; k < 3; k++) begin
      in0_valid = 1'b1; in0_data = WIDTH'(3 + k);
      cycle();
    end
    out1_ready = 1'b0;
    in0_data   = 5'h06;
    for (int k = 0; k < 4; k++) begin
      #1;
      chk("t3_stall_ready", 32'(in0_ready),  32'd0);
      chk("t3_stall_occ",   32'(occupancy),  32'd3);
      chk("t3_stall_data",  32'(out1_data),  32'h03);
      cycle();
    end
    out1_ready = 1'b1;
    idle_inputs();
    for (int k = 0; k < DEPTH + 2; k++) cycle();

    // Head-of-line blocking: an OUTPUT_0 beat waits behind a stalled OUTPUT_1 head.
    out1_ready = 1'b0; out0_ready = 1'b1;
    in0_valid = 1'b1; in0_data = 5'h07;
    cycle();
    idle_inputs();
    in1_valid = 1'b1; in1_data = 5'h15;
    cycle();
    idle_inputs();
    for (int k = 0; k < 6; k++) begin
      #1 chk("t4_hol_out0", 32'(out0_valid), 32'd0);
      cycle();
    end
    out1_ready = 1'b1;
    for (int k = 0; k < DEPTH + 2; k++) cycle();

    // Reset with two beats in flight and prio left at 1.
    in0_valid = 1'b1; in1_valid = 1'b1; in0_data = 5'h09; in1_data = 5'h19;
    cycle();
    in0_valid = 1'b0;
    cycle();
    idle_inputs();
    do_reset();
    for (int k = 0; k < DEPTH + 2; k++) cycle();
    in0_valid = 1'b1; in1_valid = 1'b1; in0_data = 5'h0C; in1_data = 5'h1C;
    #1 chk("t5_prio_cleared", 32'(in0_ready), 32'd1);
    cycle();
    idle_inputs();
    for (int k = 0; k < DEPTH + 1; k++) cycle();

    // Straight routing instance: INPUT_1 goes to OUTPUT_1.
    ns_in1_valid = 1'b1; ns_in1_data = 5'h1F;
    #1 chk("t6_in1_ready", 32'(ns_in1_ready), 32'd1);
    @(negedge CLK);
    ns_in1_valid = 1'b0;
    lat = -1; seen0 = 1'b0; ns_got = '0;
    for (int k = 1; k <= 8; k++) begin
      #1;
      if (ns_out0_valid) seen0 = 1'b1;
      if (ns_out1_valid && lat < 0) begin
        lat    = k;
        ns_got = ns_out1_data;
      end
      @(negedge CLK);
    end
    chk("t6_latency",    32'(lat),    32'd3);
    chk("t6_out1_data",  32'(ns_got), 32'h1F);
    chk("t6_out0_never", 32'(seen0),  32'd0);

    // Random traffic with one mid-stream reset.
    for (int n = 0; n < 600; n++) begin
      if (n == 300) begin
        idle_inputs();
        do_reset();
      end
      in0_valid  = ($urandom_range(0, 3) != 0);
      in1_valid  = ($urandom_range(0, 3) != 0);
      in0_data   = WIDTH'($urandom);
      in1_data   = WIDTH'($urandom);
      out0_ready = ($urandom_range(0, 9) < 7);
      out1_ready = ($urandom_range(0, 9) < 7);
      cycle();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
